// File: rtl/mipi_init_sequencer_if.sv
// I2C write handshake between the init sequencer (master) and the shared
// camera I2C master (slave). One write is offered per req assertion.
interface mipi_init_sequencer_if;
   logic        i2c_req;
   logic [15:0] i2c_reg;
   logic [15:0] i2c_data;
   logic        i2c_ack;
   logic        i2c_err;

   modport master (
      output i2c_req,
      output i2c_reg,
      output i2c_data,
      input  i2c_ack,
      input  i2c_err
   );

   modport slave (
      input  i2c_req,
      input  i2c_reg,
      input  i2c_data,
      output i2c_ack,
      output i2c_err
   );
endinterface

// File: rtl/mipi_init_sequencer.sv
// D8M MIPI bridge power-up and register-configuration sequencer.
// Releases pwdn_n then reset_n on a fixed schedule, then walks a
// synchronous command table issuing I2C writes (with retry/timeout)
// and timed delays. Reports busy/done/error and the failing index.
module mipi_init_sequencer #(
   parameter int TBL_AW         = 6,
   parameter int PWDN_CYCLES    = 5000,
   parameter int RESET_CYCLES   = 5000,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int MAX_RETRY      = 3,
   parameter int DELAY_SCALE    = 50
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic [TBL_AW-1:0]     tbl_addr,
   input  logic [33:0]           tbl_data,
   mipi_init_sequencer_if.master i2c,
   output logic                  mipi_pwdn_n,
   output logic                  mipi_reset_n,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [TBL_AW-1:0]     err_index
);

   // One shared timer covers the power-down, reset and ack-timeout phases.
   localparam int PH_MAX  = (PWDN_CYCLES > RESET_CYCLES) ? PWDN_CYCLES : RESET_CYCLES;
   localparam int TMR_MAX = (PH_MAX > TIMEOUT_CYCLES) ? PH_MAX : TIMEOUT_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int DLY_W   = 16 + $clog2(DELAY_SCALE + 1);
   localparam int RTY_W   = $clog2(MAX_RETRY + 2);

   localparam logic [TMR_W-1:0] PWDN_LAST = TMR_W'(PWDN_CYCLES - 1);
   localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RESET_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [DLY_W-1:0] DLY_MULT  = DLY_W'(DELAY_SCALE);
   localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRY);

   typedef enum logic [3:0] {
      S_IDLE,
      S_PWDN,
      S_RST,
      S_FETCH,
      S_WAIT_ROM,
      S_DECODE,
      S_ISSUE,
      S_WAIT_ACK,
      S_GAP,
      S_DELAY,
      S_DONE,
      S_ERROR
   } state_t;

   typedef enum logic [1:0] {
      E_WRITE = 2'b00,
      E_DELAY = 2'b01,
      E_SKIP  = 2'b10,
      E_END   = 2'b11
   } entry_t;

   state_t            state;
   entry_t            ent_type;
   logic [15:0]       ent_hi;
   logic [15:0]       ent_lo;
   logic [TMR_W-1:0]  tmr;
   logic [DLY_W-1:0]  dly;
   logic [RTY_W-1:0]  retry;

   logic              last_entry;
   state_t            adv_state;
   logic [TBL_AW-1:0] adv_addr;

   // Where "advance to the next entry" lands: the final table slot is an implicit end.
   always_comb begin
      last_entry = (tbl_addr == '1);
      adv_state  = S_FETCH;
      adv_addr   = tbl_addr + 1'b1;
      if (last_entry) begin
         adv_state = S_DONE;
         adv_addr  = tbl_addr;
      end
   end

   // Sequencer FSM with registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         ent_type      <= E_WRITE;
         ent_hi        <= '0;
         ent_lo        <= '0;
         tmr           <= '0;
         dly           <= '0;
         retry         <= '0;
         tbl_addr      <= '0;
         err_index     <= '0;
         i2c.i2c_req   <= 1'b0;
         i2c.i2c_reg   <= '0;
         i2c.i2c_data  <= '0;
         mipi_pwdn_n   <= 1'b0;
         mipi_reset_n  <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  done         <= 1'b0;
                  error        <= 1'b0;
                  err_index    <= '0;
                  busy         <= 1'b1;
                  tbl_addr     <= '0;
                  tmr          <= '0;
                  i2c.i2c_req  <= 1'b0;
                  mipi_pwdn_n  <= 1'b0;
                  mipi_reset_n <= 1'b0;
                  state        <= S_PWDN;
               end
            end

            S_PWDN: begin
               if (tmr == PWDN_LAST) begin
                  tmr         <= '0;
                  mipi_pwdn_n <= 1'b1;
                  state       <= S_RST;
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end

            S_RST: begin
               if (tmr == RST_LAST) begin
                  tmr          <= '0;
                  mipi_reset_n <= 1'b1;
                  state        <= S_FETCH;
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end

            S_FETCH: state <= S_WAIT_ROM;

            // Table data is valid here (address was presented during FETCH).
            S_WAIT_ROM: begin
               ent_type <= entry_t'(tbl_data[33:32]);
               ent_hi   <= tbl_data[31:16];
               ent_lo   <= tbl_data[15:0];
               state    <= S_DECODE;
            end

            S_DECODE: begin
               case (ent_type)
                  E_WRITE: begin
                     i2c.i2c_reg  <= ent_hi;
                     i2c.i2c_data <= ent_lo;
                     retry        <= '0;
                     state        <= S_ISSUE;
                  end
                  E_DELAY: begin
                     if (ent_hi == 16'd0) begin
                        tbl_addr <= adv_addr;
                        state    <= adv_state;
                        if (last_entry) begin
                           busy <= 1'b0;
                           done <= 1'b1;
                        end
                     end else begin
                        dly   <= DLY_W'(ent_hi) * DLY_MULT;
                        state <= S_DELAY;
                     end
                  end
                  E_SKIP: begin
                     tbl_addr <= adv_addr;
                     state    <= adv_state;
                     if (last_entry) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                     end
                  end
                  E_END: begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end
               endcase
            end

            S_ISSUE: begin
               i2c.i2c_req <= 1'b1;
               tmr         <= '0;
               state       <= S_WAIT_ACK;
            end

            // err outranks ack; a timeout counts as a failed attempt.
            S_WAIT_ACK: begin
               if (i2c.i2c_err || (!i2c.i2c_ack && tmr == TMO_LAST)) begin
                  i2c.i2c_req <= 1'b0;
                  if (retry < RTY_LIMIT) begin
                     retry <= retry + 1'b1;
                     state <= S_GAP;
                  end else begin
                     err_index <= tbl_addr;
                     error     <= 1'b1;
                     busy      <= 1'b0;
                     state     <= S_ERROR;
                  end
               end else if (i2c.i2c_ack) begin
                  i2c.i2c_req <= 1'b0;
                  tbl_addr    <= adv_addr;
                  state       <= adv_state;
                  if (last_entry) begin
                     busy <= 1'b0;
                     done <= 1'b1;
                  end
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end

            // Guarantees req is low for at least one cycle between attempts.
            S_GAP: state <= S_ISSUE;

            // Occupies exactly count*DELAY_SCALE cycles.
            S_DELAY: begin
               if (dly <= DLY_W'(1)) begin
                  tbl_addr <= adv_addr;
                  state    <= adv_state;
                  if (last_entry) begin
                     busy <= 1'b0;
                     done <= 1'b1;
                  end
               end else begin
                  dly <= dly - 1'b1;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mipi_init_sequencer.sv
// Self-checking bench for mipi_init_sequencer: directed scenarios plus
// randomized tables/master responses checked against a table-walk model.
module tb_mipi_init_sequencer;
   localparam int AW  = 3;
   localparam int PW  = 10;
   localparam int RW  = 8;
   localparam int TMO = 20;
   localparam int MR  = 3;
   localparam int DS  = 50;
   localparam int NT  = 1 << AW;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] tbl_addr;
   logic [33:0]   tbl_data;
   logic          pwdn_n;
   logic          reset_n;
   logic          busy;
   logic          done;
   logic          error;
   logic [AW-1:0] err_index;

   mipi_init_sequencer_if bus ();

   mipi_init_sequencer #(
      .TBL_AW(AW), .PWDN_CYCLES(PW), .RESET_CYCLES(RW),
      .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MR), .DELAY_SCALE(DS)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .tbl_addr(tbl_addr), .tbl_data(tbl_data),
      .i2c(bus),
      .mipi_pwdn_n(pwdn_n), .mipi_reset_n(reset_n),
      .busy(busy), .done(done), .error(error), .err_index(err_index)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Command table with one cycle of read latency.
   logic [33:0] tbl [NT];
   always @(posedge clk) tbl_data <= tbl[tbl_addr];

   int          errors = 0;
   int          checks = 0;
   int          plan[$];          // per-attempt response: 0 ack, 1 err, 2 silent
   int          resp_q[$];
   logic [31:0] log_q[$];
   int          req_q[$];
   int          ack_q[$];
   int          stable_bad = 0;
   int          stray_req = 0;
   int          stray_done = 0;
   logic [31:0] exp_q[$];
   bit          exp_done;
   bit          exp_error;
   int          exp_idx;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // I2C master model: one response per req pulse, taken from resp_q.
   initial begin
      bit          seen;
      int          resp;
      int          lat;
      logic [31:0] cur;
      seen = 0;
      cur  = '0;
      bus.i2c_ack = 1'b0;
      bus.i2c_err = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.i2c_req === 1'b1) begin
            if (!seen) begin
               seen = 1;
               cur  = {bus.i2c_reg, bus.i2c_data};
               log_q.push_back(cur);
               req_q.push_back(cyc);
               resp = (resp_q.size() > 0) ? resp_q.pop_front() : 2;
               if (resp != 2) begin
                  lat = $urandom_range(1, 6);
                  repeat (lat - 1) begin
                     @(negedge clk);
                     if ({bus.i2c_reg, bus.i2c_data} !== cur || bus.i2c_req !== 1'b1) stable_bad++;
                  end
                  if (resp == 0) begin
                     bus.i2c_ack = 1'b1;
                     ack_q.push_back(cyc);
                  end else begin
                     bus.i2c_err = 1'b1;
                     if ($urandom_range(0, 1) == 1) bus.i2c_ack = 1'b1;
                  end
                  @(negedge clk);
                  bus.i2c_ack = 1'b0;
                  bus.i2c_err = 1'b0;
               end
            end else if ({bus.i2c_reg, bus.i2c_data} !== cur) begin
               stable_bad++;
            end
         end else begin
            seen = 0;
            if (stray_done != stray_req) begin
               bus.i2c_ack = 1'b1;
               bus.i2c_err = 1'b1;
               @(negedge clk);
               bus.i2c_ack = 1'b0;
               bus.i2c_err = 1'b0;
               stray_done++;
            end
         end
      end
   end

   // Reference: walk the table by its rules, consuming one plan response per attempt.
   task automatic build_expect();
      int         p;
      int         r;
      bit         ok;
      bit         fin;
      logic [1:0] t;
      p = 0;
      fin = 0;
      exp_q.delete();
      exp_done = 0;
      exp_error = 0;
      exp_idx = 0;
      for (int i = 0; i < NT && !fin; i++) begin
         t = tbl[i][33:32];
         if (t == 2'b11) begin
            fin = 1;
         end else if (t == 2'b00) begin
            ok = 0;
            for (int a = 0; a <= MR && !ok; a++) begin
               r = (p < plan.size()) ? plan[p] : 2;
               p++;
               exp_q.push_back(tbl[i][31:0]);
               if (r == 0) ok = 1;
            end
            if (!ok) begin
               exp_error = 1;
               exp_idx = i;
               fin = 1;
            end
         end
      end
      exp_done = !exp_error;
   endtask

   task automatic set_ent(input int i, input logic [1:0] t, input logic [15:0] hi, input logic [15:0] lo);
      tbl[i] = {t, hi, lo};
   endtask

   task automatic fill_junk();
      for (int i = 0; i < NT; i++) tbl[i] = {2'($urandom), 16'($urandom), 16'($urandom)};
   endtask

   task automatic check_cleared(input string tag);
      check({tag, ":req"}, bus.i2c_req, 1'b0);
      check({tag, ":busy"}, busy, 1'b0);
      check({tag, ":done"}, done, 1'b0);
      check({tag, ":error"}, error, 1'b0);
      check({tag, ":pwdn_n"}, pwdn_n, 1'b0);
      check({tag, ":reset_n"}, reset_n, 1'b0);
      check({tag, ":tbl_addr"}, tbl_addr, '0);
      check({tag, ":err_index"}, err_index, '0);
   endtask

   task automatic run_seq(input string tag, input bit pins, input bit hold);
      int n;
      build_expect();
      resp_q = plan;
      log_q.delete();
      req_q.delete();
      ack_q.delete();
      stable_bad = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      check({tag, ":start_busy"}, busy, 1'b1);
      check({tag, ":start_done"}, done, 1'b0);
      check({tag, ":start_error"}, error, 1'b0);
      check({tag, ":start_pwdn"}, pwdn_n, 1'b0);
      if (!hold) start = 1'b0;
      if (pins) begin
         stray_req++;
         repeat (PW - 1) @(posedge clk);
         #1;
         check({tag, ":pwdn_before"}, pwdn_n, 1'b0);
         @(posedge clk);
         #1;
         check({tag, ":pwdn_rise"}, pwdn_n, 1'b1);
         check({tag, ":rstn_held"}, reset_n, 1'b0);
         repeat (RW - 1) @(posedge clk);
         #1;
         check({tag, ":rstn_before"}, reset_n, 1'b0);
         check({tag, ":busy_mid"}, busy, 1'b1);
         @(posedge clk);
         #1;
         check({tag, ":rstn_rise"}, reset_n, 1'b1);
      end
      n = 0;
      while (!(done === 1'b1 || error === 1'b1) && n < 6000) begin
         @(posedge clk);
         #1;
         n++;
      end
      start = 1'b0;
      check({tag, ":finished_in_budget"}, n < 6000, 1'b1);
      check({tag, ":nreq"}, log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
         check($sformatf("%s:wr%0d", tag, i), log_q[i], exp_q[i]);
      check({tag, ":done"}, done, exp_done);
      check({tag, ":error"}, error, exp_error);
      check({tag, ":busy_end"}, busy, 1'b0);
      check({tag, ":req_end"}, bus.i2c_req, 1'b0);
      check({tag, ":pins_end"}, {pwdn_n, reset_n}, 2'b11);
      check({tag, ":stable"}, stable_bad, 0);
      if (exp_error) check({tag, ":err_index"}, err_index, exp_idx);
      else check({tag, ":err_index_clr"}, err_index, '0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int g01;
      int g12;
      int r;
      logic [1:0] t;
      reset = 1'b1;
      start = 1'b0;
      fill_junk();
      #1;
      check_cleared("reset_async");
      repeat (3) @(posedge clk);
      #1;
      check_cleared("reset_held");
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_cleared("idle");

      // Two writes then end, with pin-release timing and a stray ack/err during PWDN.
      fill_junk();
      set_ent(0, 2'b00, 16'h0004, 16'h0004);
      set_ent(1, 2'b00, 16'h0002, 16'h0001);
      set_ent(2, 2'b11, 16'h0000, 16'h0000);
      plan = '{0, 0};
      run_seq("basic", 1, 0);

      // Re-start from DONE; delay of 3 units between the 2nd and 3rd writes.
      fill_junk();
      set_ent(0, 2'b00, 16'h1111, 16'hA0A0);
      set_ent(1, 2'b00, 16'h2222, 16'hB1B1);
      set_ent(2, 2'b01, 16'd3, 16'h0000);
      set_ent(3, 2'b00, 16'h3333, 16'hC2C2);
      set_ent(4, 2'b11, 16'h0000, 16'h0000);
      plan = '{0, 0, 0};
      run_seq("delay", 0, 0);
      if (req_q.size() == 3 && ack_q.size() == 3) begin
         g01 = req_q[1] - ack_q[0];
         g12 = req_q[2] - ack_q[1];
         // ack is sampled on the next edge, then FETCH..ISSUE spans 4 cycles.
         check("delay:write_gap", g01, 5);
         // Delay entry adds its own fetch/wait/decode (3) plus 3*DS cycles.
         check("delay:delay_extra", g12 - g01, 3 * DS + 3);
      end else begin
         check("delay:gap_samples", {req_q.size(), ack_q.size()}, {32'd3, 32'd3});
      end

      // Entry 1 fails twice (err) then succeeds.
      fill_junk();
      set_ent(0, 2'b00, 16'h0100, 16'h0001);
      set_ent(1, 2'b00, 16'h0200, 16'h0002);
      set_ent(2, 2'b11, 16'h0000, 16'h0000);
      plan = '{0, 1, 1, 0};
      run_seq("retry", 0, 0);

      // Master silent on entry 1: initial attempt plus MR retries, then ERROR.
      fill_junk();
      set_ent(0, 2'b00, 16'h0A00, 16'h000A);
      set_ent(1, 2'b00, 16'h0B00, 16'h000B);
      set_ent(2, 2'b00, 16'h0C00, 16'h000C);
      set_ent(3, 2'b11, 16'h0000, 16'h0000);
      plan = '{0, 2, 2, 2, 2};
      run_seq("timeout", 0, 0);

      // start held high for the whole run must not restart the sequence.
      fill_junk();
      set_ent(0, 2'b10, 16'hFFFF, 16'hFFFF);
      set_ent(1, 2'b00, 16'h0055, 16'h00AA);
      set_ent(2, 2'b01, 16'd0, 16'h0000);
      set_ent(3, 2'b11, 16'h0000, 16'h0000);
      plan = '{0};
      run_seq("hold_start", 0, 1);

      // Randomized tables and master behaviour; iteration 0 has no end entry.
      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < NT; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55) t = 2'b00;
            else if (r < 70) t = 2'b01;
            else if (r < 85) t = 2'b10;
            else t = (it == 0) ? 2'b10 : 2'b11;
            set_ent(i, t, (t == 2'b01) ? 16'($urandom_range(0, 2)) : 16'($urandom), 16'($urandom));
         end
         plan.delete();
         for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 99);
            plan.push_back((r < 70) ? 0 : (r < 93) ? 1 : 2);
         end
         run_seq($sformatf("rand%0d", it), 0, 0);
      end

      // Asynchronous reset while waiting for an ack.
      fill_junk();
      set_ent(0, 2'b00, 16'h7777, 16'h8888);
      set_ent(1, 2'b11, 16'h0000, 16'h0000);
      resp_q.delete();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (bus.i2c_req !== 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("midreset:req_seen", bus.i2c_req, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check_cleared("midreset");
      @(negedge clk);
      reset = 1'b0;

      // Normal operation after the mid-run reset.
      fill_junk();
      set_ent(0, 2'b00, 16'h0042, 16'h0024);
      set_ent(1, 2'b11, 16'h0000, 16'h0000);
      plan = '{1, 0};
      run_seq("after_reset", 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
